// File: rtl/nonrestoring_divider_pkg.sv
// Shared definitions for the sequential non-restoring divider.
//   DIV_WIDTH  : default operand width
//   CNT_W      : iteration counter width for the default operand width
//   S_*        : 4-bit state encodings, div_state_e built on them
//   div_ctrl_t : control strobes from the control unit to the datapath
package nonrestoring_divider_pkg;

    localparam int DIV_WIDTH = 8;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_w(DIV_WIDTH);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LOAD_A  = 4'd1;
    localparam logic [3:0] S_LOAD_Q  = 4'd2;
    localparam logic [3:0] S_LOAD_M  = 4'd3;
    localparam logic [3:0] S_CHECK   = 4'd4;
    localparam logic [3:0] S_STEP    = 4'd5;
    localparam logic [3:0] S_CORRECT = 4'd6;
    localparam logic [3:0] S_OUT_Q   = 4'd7;
    localparam logic [3:0] S_OUT_R   = 4'd8;
    localparam logic [3:0] S_ERR     = 4'd9;

    typedef enum logic [3:0] {
        IDLE    = S_IDLE,
        LOAD_A  = S_LOAD_A,
        LOAD_Q  = S_LOAD_Q,
        LOAD_M  = S_LOAD_M,
        CHECK   = S_CHECK,
        STEP    = S_STEP,
        CORRECT = S_CORRECT,
        OUT_Q   = S_OUT_Q,
        OUT_R   = S_OUT_R,
        ERR     = S_ERR
    } div_state_e;

    typedef struct packed {
        logic ld_a;
        logic ld_q;
        logic ld_m;
        logic step;
        logic sub;
        logic correct;
        logic out_q;
        logic out_r;
        logic err;
    } div_ctrl_t;

endpackage

// File: rtl/nonrestoring_divider_control_unit.sv
// Control unit of the non-restoring divider: state register, next-state
// logic and Moore-decoded control strobes.
//   clk, rst_b    : clock, async active-low reset
//   bgn           : start request, only looked at in IDLE
//   a_sign        : sign bit of the partial remainder A
//   m_zero        : divisor register is zero
//   ovf           : dividend high half >= divisor (quotient too wide)
//   is_count_last : iteration counter is at its last value
//   ctrl          : strobes to the datapath
module div_control_unit
    import nonrestoring_divider_pkg::*;
(
    input  logic      clk,
    input  logic      rst_b,
    input  logic      bgn,
    input  logic      a_sign,
    input  logic      m_zero,
    input  logic      ovf,
    input  logic      is_count_last,
    output div_ctrl_t ctrl
);

    div_state_e state;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (bgn) state <= LOAD_A;
                LOAD_A:  state <= LOAD_Q;
                LOAD_Q:  state <= LOAD_M;
                LOAD_M:  state <= CHECK;
                CHECK:   state <= (m_zero || ovf) ? ERR : STEP;
                STEP:    if (is_count_last) state <= CORRECT;
                CORRECT: state <= OUT_Q;
                OUT_Q:   state <= OUT_R;
                OUT_R:   state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes depend only on the registered state (plus A's sign, which is
    // itself a register), so no input reaches the outputs combinationally.
    always_comb begin
        ctrl         = '0;
        ctrl.ld_a    = (state == LOAD_A);
        ctrl.ld_q    = (state == LOAD_Q);
        ctrl.ld_m    = (state == LOAD_M);
        ctrl.step    = (state == STEP);
        // Non-restoring rule: subtract while the partial remainder is
        // non-negative, add back while it is negative.
        ctrl.sub     = (state == STEP) && !a_sign;
        ctrl.correct = (state == CORRECT) && a_sign;
        ctrl.out_q   = (state == OUT_Q);
        ctrl.out_r   = (state == OUT_R);
        ctrl.err     = (state == ERR);
    end

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential unsigned non-restoring divider, one quotient bit per cycle.
// Operands arrive over inbus on consecutive cycles (dividend high, dividend
// low, divisor); the quotient and then the remainder leave on outbus with
// done high. Divide by zero and quotient overflow end in a one-cycle ERR.
//   clk, rst_b : clock, async active-low reset
//   bgn        : start request (IDLE only)
//   inbus      : operand input
//   outbus     : quotient (OUT_Q), remainder (OUT_R), else 0
//   done       : high in OUT_Q, OUT_R and ERR
//   err        : high in ERR only
module nonrestoring_divider
    import nonrestoring_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             bgn,
    input  logic [WIDTH-1:0] inbus,
    output logic [WIDTH-1:0] outbus,
    output logic             done,
    output logic             err
);

    localparam int CW = cnt_w(WIDTH);

    div_ctrl_t ctrl;

    logic [WIDTH:0]   a;      // signed partial remainder
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0] a_sh, opa, opb, sum;

    div_control_unit u_ctrl (
        .clk           (clk),
        .rst_b         (rst_b),
        .bgn           (bgn),
        .a_sign        (a[WIDTH]),
        .m_zero        (m == '0),
        .ovf           (a[WIDTH-1:0] >= m),
        .is_count_last (cnt == CW'(WIDTH - 1)),
        .ctrl          (ctrl)
    );

    // {A,Q} shifted left by one. A's top bit drops out: the add/sub result
    // always lands back in [-M, M), so modulo-2^(WIDTH+1) arithmetic is exact.
    assign a_sh = {a[WIDTH-1:0], q[WIDTH-1]};

    // Single shared adder: STEP works on the shifted remainder, CORRECT on A.
    assign opa = ctrl.step ? a_sh : a;
    assign opb = {1'b0, m};
    assign sum = ctrl.sub ? (opa - opb) : (opa + opb);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            a   <= '0;
            q   <= '0;
            m   <= '0;
            cnt <= '0;
        end else begin
            if (ctrl.ld_a) a <= {1'b0, inbus};
            if (ctrl.ld_q) q <= inbus;
            if (ctrl.ld_m) begin
                m   <= inbus;
                cnt <= '0;
            end
            if (ctrl.step) begin
                a   <= sum;
                q   <= {q[WIDTH-2:0], ~sum[WIDTH]};
                cnt <= cnt + CW'(1);
            end
            if (ctrl.correct) a <= sum;
        end
    end

    always_comb begin
        outbus = '0;
        if (ctrl.out_q)      outbus = q;
        else if (ctrl.out_r) outbus = a[WIDTH-1:0];
    end

    assign done = ctrl.out_q | ctrl.out_r | ctrl.err;
    assign err  = ctrl.err;

endmodule

// File: tb/tb_nonrestoring_divider.sv
module tb_nonrestoring_divider;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        bit         e;
    } exp_t;

    logic       clk = 0;
    logic       rst_b = 0;
    logic       bgn = 0;
    logic [7:0] inbus = 0;
    logic [7:0] outbus;
    logic       done;
    logic       err;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    nonrestoring_divider #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_b  (rst_b),
        .bgn    (bgn),
        .inbus  (inbus),
        .outbus (outbus),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation. Caller has set bgn=1 before the edge that starts it
    // (edge 0); k counts the cycle being observed at each falling edge.
    // hold: keep bgn toggling randomly and leave it high for the next start.
    // abort_at: cycle at which rst_b is pulsed (0 = none).
    task automatic run_op(input logic [7:0] dh, input logic [7:0] dl,
                          input logic [7:0] dv, input bit hold, input int abort_at);
        exp_t e, cur;
        logic [15:0] dd, qq, rr;
        int last;
        dd = {dh, dl};
        e.e = (dv == 0) || (dh >= dv);
        e.q = 0;
        e.r = 0;
        if (!e.e) begin
            qq  = dd / {8'd0, dv};
            rr  = dd % {8'd0, dv};
            e.q = qq[7:0];
            e.r = rr[7:0];
        end
        if (abort_at == 0) sb.push_back(e);
        cur = '{q: 8'hxx, r: 8'hxx, e: 1'b0};
        last = e.e ? 6 : 16;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                #1 rst_b = 0;
                #1;
                chk("abort_done", done, 0);
                chk("abort_err", err, 0);
                chk("abort_outbus", outbus, 0);
                @(negedge clk);
                bgn = 0;
                rst_b = 1;
                return;
            end
            if ((e.e && k == 5) || (!e.e && k == 14)) begin
                if (sb.size() == 0) chk("sb_empty", 1, 0);
                else cur = sb.pop_front();
            end
            if (e.e) begin
                chk($sformatf("done_c%0d", k), done, (k == 5));
                chk($sformatf("err_c%0d", k), err, (k == 5));
                chk($sformatf("outbus_c%0d", k), outbus, 0);
            end else begin
                chk($sformatf("done_c%0d", k), done, (k == 14 || k == 15));
                chk($sformatf("err_c%0d", k), err, 0);
                chk($sformatf("outbus_c%0d", k), outbus,
                    (k == 14) ? cur.q : (k == 15) ? cur.r : 8'h00);
            end
            case (k)
                1: inbus = dh;
                2: inbus = dl;
                3: inbus = dv;
                default: inbus = 8'($urandom);
            endcase
            if (hold) bgn = (k == last) ? 1'b1 : 1'($urandom_range(0, 1));
            else      bgn = 0;
        end
    endtask

    task automatic start();
        @(negedge clk);
        bgn = 1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_done", done, 0);
            chk("idle_outbus", outbus, 0);
        end
    endtask

    initial begin
        logic [7:0] rh, rl, rm;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_outbus", outbus, 0);
        rst_b = 1;
        idle_cycles(2);

        // 1000 / 7
        start(); run_op(8'h03, 8'hE8, 8'h07, 0, 0);
        idle_cycles(1);

        // 0x00FF / 0xFF and 0xFEFF / 0xFF
        start(); run_op(8'h00, 8'hFF, 8'hFF, 0, 0);
        start(); run_op(8'hFE, 8'hFF, 8'hFF, 0, 0);

        // divide by zero
        start(); run_op(8'h12, 8'h34, 8'h00, 0, 0);
        idle_cycles(1);

        // high half equal to divisor overflows; one below fits
        start(); run_op(8'h10, 8'h00, 8'h10, 0, 0);
        start(); run_op(8'h0F, 8'hFF, 8'h10, 0, 0);

        // reset during STEP, then 100 / 3 at normal latency
        start(); run_op(8'h00, 8'h64, 8'h05, 0, 8);
        idle_cycles(2);
        start(); run_op(8'h00, 8'h64, 8'h03, 0, 0);

        // bgn held high, back-to-back operations, random operands
        start();
        for (int i = 0; i < 8; i++) begin
            rm = 8'($urandom_range(1, 255));
            rh = 8'($urandom_range(0, rm - 1));
            rl = 8'($urandom);
            if (i == 4) rm = 8'h00;      // an error case inside the stream
            if (i == 6) rh = rm;         // an overflow case inside the stream
            run_op(rh, rl, rm, 1, 0);
        end
        bgn = 0;
        idle_cycles(3);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
